// File: rtl/ds_pkg.sv
// Shared types and helpers for DataStream arbitration blocks.
package ds_pkg;

  typedef enum logic {IDLE, GRANT} ds_arb_state_t;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int ds_cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ds_rr_pick.sv
// Wrapped priority search: first set req bit at or after ptr, wrapping to 0.
module ds_rr_pick #(
  parameter int INPUTS = 2
) (
  input  logic [INPUTS-1:0]         req,
  input  logic [$clog2(INPUTS)-1:0] ptr,
  output logic                      found,
  output logic [$clog2(INPUTS)-1:0] idx
);
  localparam int PW = $clog2(INPUTS);

  logic          hi_found;
  logic [PW-1:0] hi_idx;
  logic [PW-1:0] lo_idx;

  // Descending scan so the lowest qualifying index is the last one written.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = INPUTS-1; k >= 0; k--) begin
      if (req[k]) begin
        lo_idx = PW'(k);
        if (k >= int'(ptr)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(k);
        end
      end
    end
  end

  assign found = |req;
  assign idx   = hi_found ? hi_idx : lo_idx;

endmodule

// File: rtl/ds_rr_arbiter.sv
// Round-robin merger of INPUTS streams into one registered stream with the
// source index tagged; a grant lasts up to BURST words.
module ds_rr_arbiter
  import ds_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int INPUTS = 2,
  parameter int BURST  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [INPUTS-1:0][WIDTH-1:0]   i_dat,
  input  logic [INPUTS-1:0]              i_val,
  output logic [INPUTS-1:0]              i_rdy,
  output logic [WIDTH-1:0]               o_dat,
  output logic                           o_val,
  input  logic                           o_rdy,
  output logic [$clog2(INPUTS)-1:0]      o_sel
);
  localparam int SW = $clog2(INPUTS);
  localparam int CW = ds_cnt_w(BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST-1);
  localparam logic [SW-1:0] SEL_LAST = SW'(INPUTS-1);

  ds_arb_state_t    state_q, state_d;
  logic [SW-1:0]    ptr_q, ptr_d;
  logic [SW-1:0]    gnt_q, gnt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             o_val_q, o_val_d;
  logic [WIDTH-1:0] o_dat_q, o_dat_d;
  logic [SW-1:0]    o_sel_q, o_sel_d;

  logic          pick_found;
  logic [SW-1:0] pick_idx;
  logic          out_free;
  logic          xfer;

  ds_rr_pick #(.INPUTS(INPUTS)) u_pick (
    .req   (i_val),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign out_free = !o_val_q || o_rdy;
  assign xfer     = (state_q == GRANT) && i_val[gnt_q] && out_free;

  always_comb begin
    i_rdy = '0;
    if (state_q == GRANT && out_free) i_rdy[gnt_q] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    o_val_d = o_val_q;
    o_dat_d = o_dat_q;
    o_sel_d = o_sel_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d   = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A source that goes idle gives up the grant even while stalled.
        if (!i_val[gnt_q] || (xfer && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          ptr_d   = (gnt_q == SEL_LAST) ? '0 : gnt_q + SW'(1);
        end else if (xfer) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      o_val_d = 1'b1;
      o_dat_d = i_dat[gnt_q];
      o_sel_d = gnt_q;
    end else if (o_rdy) begin
      o_val_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
      o_val_q <= 1'b0;
      o_dat_q <= '0;
      o_sel_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      o_val_q <= o_val_d;
      o_dat_q <= o_dat_d;
      o_sel_q <= o_sel_d;
    end
  end

  assign o_val = o_val_q;
  assign o_dat = o_dat_q;
  assign o_sel = o_sel_q;

endmodule

// File: tb/tb_ds_rr_arbiter.sv
// Self-checking bench: two arbiter configurations (2x burst 4, 3x burst 1),
// directed scenarios plus randomized backpressure against a stream-order model.
module tb_ds_rr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic [1:0][7:0] a_dat;
  logic [1:0]      a_val, a_rdy;
  logic [7:0]      a_odat;
  logic            a_oval, a_ordy;
  logic            a_osel;

  logic [2:0][7:0] b_dat;
  logic [2:0]      b_val, b_rdy;
  logic [7:0]      b_odat;
  logic            b_oval, b_ordy;
  logic [1:0]      b_osel;

  ds_rr_arbiter #(.WIDTH(8), .INPUTS(2), .BURST(4)) dut_a (
    .clk(clk), .reset(reset), .i_dat(a_dat), .i_val(a_val), .i_rdy(a_rdy),
    .o_dat(a_odat), .o_val(a_oval), .o_rdy(a_ordy), .o_sel(a_osel)
  );

  ds_rr_arbiter #(.WIDTH(8), .INPUTS(3), .BURST(1)) dut_b (
    .clk(clk), .reset(reset), .i_dat(b_dat), .i_val(b_val), .i_rdy(b_rdy),
    .o_dat(b_odat), .o_val(b_oval), .o_rdy(b_ordy), .o_sel(b_osel)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int a_n[2];
  int b_n[3];
  int a_lim[2];
  logic [1:0] a_en;
  logic [2:0] b_en;
  int a_got[$];
  int a_gcyc[$];
  int b_got[$];

  // Expected tagged word: source index in bits above the data byte.
  function automatic int wd(input int sel, input int n);
    return sel * 256 + (((sel + 1) * 16 + n) % 256);
  endfunction

  // One clock: drive sources, log handshakes, advance source counters.
  task automatic tick();
    logic [1:0] af;
    logic [2:0] bf;
    logic       rst_now;
    for (int k = 0; k < 2; k++) begin
      a_dat[k] = 8'((k + 1) * 16 + a_n[k]);
      a_val[k] = a_en[k] && (a_n[k] < a_lim[k]);
    end
    for (int k = 0; k < 3; k++) begin
      b_dat[k] = 8'((k + 1) * 16 + b_n[k]);
      b_val[k] = b_en[k];
    end
    #1;
    af = a_val & a_rdy;
    bf = b_val & b_rdy;
    rst_now = reset;
    if (rst_now) begin
      if (a_oval && a_ordy) begin
        a_got.push_back(int'(a_osel) * 256 + int'(a_odat));
        a_gcyc.push_back(cyc);
      end
      if (b_oval && b_ordy) b_got.push_back(int'(b_osel) * 256 + int'(b_odat));
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (rst_now) begin
      for (int k = 0; k < 2; k++) if (af[k]) a_n[k]++;
      for (int k = 0; k < 3; k++) if (bf[k]) b_n[k]++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int k = 0; k < 2; k++) a_n[k] = 0;
    for (int k = 0; k < 3; k++) b_n[k] = 0;
    a_got.delete();
    a_gcyc.delete();
    b_got.delete();
  endtask

  task automatic test_reset();
    a_en = 2'b11; a_lim[0] = 1000; a_lim[1] = 1000; a_ordy = 1'b1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_chk++; if (a_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_i_rdy: got %b want 00", a_rdy); end
    n_chk++; if (a_oval !== 1'b0) begin n_fail++; $display("FAIL reset_o_val: got %b want 0", a_oval); end
    n_chk++; if (a_odat !== 8'h00) begin n_fail++; $display("FAIL reset_o_dat: got %h want 00", a_odat); end
    n_chk++; if (a_osel !== 1'b0) begin n_fail++; $display("FAIL reset_o_sel: got %b want 0", a_osel); end
    reset = 1'b1;
    a_n[0] = 0; a_n[1] = 0;
    tick();
    n_chk++; if (a_oval !== 1'b0 || a_rdy !== 2'b01) begin
      n_fail++; $display("FAIL reset_clk1: got val %b rdy %b want val 0 rdy 01", a_oval, a_rdy); end
    tick();
    n_chk++; if (a_oval !== 1'b1 || a_osel !== 1'b0 || a_odat !== 8'h10) begin
      n_fail++; $display("FAIL reset_clk2: got val %b sel %b dat %h want 1 0 10", a_oval, a_osel, a_odat); end
  endtask

  task automatic test_burst();
    logic tr[16];
    logic exp_v;
    a_en = 2'b11; a_lim[0] = 1000; a_lim[1] = 1000; a_ordy = 1'b1; b_en = 3'b000;
    do_reset();
    for (int c = 0; c < 16; c++) begin
      tick();
      tr[c] = a_oval;
    end
    // Grant setup cycle, then BURST words and one bubble per grant.
    for (int c = 0; c < 16; c++) begin
      exp_v = (c != 0) && (((c - 1) % 5) < 4);
      n_chk++; if (tr[c] !== exp_v) begin
        n_fail++; $display("FAIL burst_val[%0d]: got %b want %b", c, tr[c], exp_v); end
    end
    n_chk++; if (a_got.size() < 12) begin
      n_fail++; $display("FAIL burst_count: got %0d want >=12", a_got.size()); end
    for (int i = 0; i < 12 && i < a_got.size(); i++) begin
      n_chk++; if (a_got[i] !== wd((i / 4) % 2, (i / 8) * 4 + i % 4)) begin
        n_fail++; $display("FAIL burst_word[%0d]: got %h want %h", i, a_got[i], wd((i / 4) % 2, (i / 8) * 4 + i % 4)); end
    end
  endtask

  task automatic test_early_release();
    int exp_w[6];
    exp_w = '{wd(0, 0), wd(0, 1), wd(1, 0), wd(1, 1), wd(1, 2), wd(1, 3)};
    a_en = 2'b11; a_lim[0] = 2; a_lim[1] = 1000; a_ordy = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) tick();
    n_chk++; if (a_got.size() < 6) begin
      n_fail++; $display("FAIL early_count: got %0d want >=6", a_got.size()); end
    for (int i = 0; i < 6 && i < a_got.size(); i++) begin
      n_chk++; if (a_got[i] !== exp_w[i]) begin
        n_fail++; $display("FAIL early_word[%0d]: got %h want %h", i, a_got[i], exp_w[i]); end
    end
    if (a_gcyc.size() >= 3) begin
      n_chk++; if (a_gcyc[2] - a_gcyc[1] < 2) begin
        n_fail++; $display("FAIL early_bubble: got gap %0d want >=2", a_gcyc[2] - a_gcyc[1]); end
    end
  endtask

  task automatic test_backpressure();
    a_en = 2'b11; a_lim[0] = 1000; a_lim[1] = 1000; a_ordy = 1'b1;
    do_reset();
    for (int c = 0; c < 3; c++) tick();
    a_ordy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_chk++; if (a_rdy !== 2'b00) begin n_fail++; $display("FAIL bp_i_rdy[%0d]: got %b want 00", i, a_rdy); end
      tick();
      n_chk++; if (a_oval !== 1'b1 || a_odat !== 8'h11 || a_osel !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got val %b dat %h sel %b want 1 11 0", i, a_oval, a_odat, a_osel); end
    end
    a_ordy = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    n_chk++; if (a_got.size() < 9) begin
      n_fail++; $display("FAIL bp_count: got %0d want >=9", a_got.size()); end
    for (int i = 0; i < 9 && i < a_got.size(); i++) begin
      n_chk++; if (a_got[i] !== wd((i / 4) % 2, (i / 8) * 4 + i % 4)) begin
        n_fail++; $display("FAIL bp_word[%0d]: got %h want %h", i, a_got[i], wd((i / 4) % 2, (i / 8) * 4 + i % 4)); end
    end
  endtask

  task automatic test_rr_wrap();
    int s;
    a_en = 2'b00; b_en = 3'b111; b_ordy = 1'b1;
    do_reset();
    for (int c = 0; c < 14; c++) tick();
    n_chk++; if (b_got.size() < 6) begin n_fail++; $display("FAIL wrap_count: got %0d want >=6", b_got.size()); end
    for (int i = 0; i < 6 && i < b_got.size(); i++) begin
      n_chk++; if (b_got[i] !== wd(i % 3, i / 3)) begin
        n_fail++; $display("FAIL wrap_word[%0d]: got %h want %h", i, b_got[i], wd(i % 3, i / 3)); end
    end
    b_en = 3'b101;
    do_reset();
    for (int c = 0; c < 12; c++) tick();
    n_chk++; if (b_got.size() < 4) begin n_fail++; $display("FAIL wrap2_count: got %0d want >=4", b_got.size()); end
    for (int i = 0; i < 4 && i < b_got.size(); i++) begin
      s = (i % 2) * 2;
      n_chk++; if (b_got[i] !== wd(s, i / 2)) begin
        n_fail++; $display("FAIL wrap2_word[%0d]: got %h want %h", i, b_got[i], wd(s, i / 2)); end
    end
    b_en = 3'b000;
  endtask

  task automatic test_reset_mid_burst();
    a_en = 2'b11; a_lim[0] = 1000; a_lim[1] = 1000; a_ordy = 1'b1;
    do_reset();
    for (int c = 0; c < 8; c++) tick();
    n_chk++; if (a_oval !== 1'b1 || a_osel !== 1'b1 || a_odat !== 8'h21) begin
      n_fail++; $display("FAIL mid_setup: got val %b sel %b dat %h want 1 1 21", a_oval, a_osel, a_odat); end
    a_ordy = 1'b0;
    reset = 1'b0;
    tick();
    n_chk++; if (a_oval !== 1'b0) begin n_fail++; $display("FAIL mid_o_val: got %b want 0", a_oval); end
    reset = 1'b1;
    a_ordy = 1'b1;
    a_got.delete();
    for (int c = 0; c < 4; c++) tick();
    n_chk++; if (a_got.size() < 1) begin
      n_fail++; $display("FAIL mid_restart_count: got %0d want >=1", a_got.size());
    end else if (a_got[0] !== wd(0, 4)) begin
      n_fail++; $display("FAIL mid_restart: got %h want %h", a_got[0], wd(0, 4));
    end
  endtask

  task automatic test_random_backpressure();
    logic       stall;
    logic [7:0] pdat;
    logic       psel;
    int         s;
    a_en = 2'b11; a_lim[0] = 1000; a_lim[1] = 1000; b_en = 3'b111;
    a_ordy = 1'b1; b_ordy = 1'b1;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      a_ordy = ($urandom % 10) < 7;
      b_ordy = ($urandom % 10) < 6;
      #1;
      n_chk++; if ((a_oval && !a_ordy && a_rdy !== 2'b00) || (b_oval && !b_ordy && b_rdy !== 3'b000)) begin
        n_fail++; $display("FAIL rand_stall_rdy[%0d]: got a %b b %b want 0", c, a_rdy, b_rdy); end
      stall = a_oval && !a_ordy;
      pdat = a_odat;
      psel = a_osel;
      tick();
      if (stall) begin
        n_chk++; if (a_oval !== 1'b1 || a_odat !== pdat || a_osel !== psel) begin
          n_fail++; $display("FAIL rand_hold[%0d]: got %b %h %b want 1 %h %b", c, a_oval, a_odat, a_osel, pdat, psel); end
      end
    end
    n_chk++; if (a_got.size() < 80 || b_got.size() < 60) begin
      n_fail++; $display("FAIL rand_progress: got a %0d b %0d want >=80 >=60", a_got.size(), b_got.size()); end
    for (int i = 0; i < a_got.size(); i++) begin
      s = (i / 4) % 2;
      n_chk++; if (a_got[i] !== wd(s, (i / 8) * 4 + i % 4)) begin
        n_fail++; $display("FAIL rand_a_word[%0d]: got %h want %h", i, a_got[i], wd(s, (i / 8) * 4 + i % 4)); end
    end
    for (int i = 0; i < b_got.size(); i++) begin
      n_chk++; if (b_got[i] !== wd(i % 3, i / 3)) begin
        n_fail++; $display("FAIL rand_b_word[%0d]: got %h want %h", i, b_got[i], wd(i % 3, i / 3)); end
    end
  endtask

  initial begin
    reset = 1'b0;
    a_en = 2'b00; b_en = 3'b000;
    a_lim[0] = 1000; a_lim[1] = 1000;
    a_ordy = 1'b1; b_ordy = 1'b1;
    a_dat = '0; a_val = '0; b_dat = '0; b_val = '0;
    for (int k = 0; k < 2; k++) a_n[k] = 0;
    for (int k = 0; k < 3; k++) b_n[k] = 0;
    @(negedge clk);
    test_reset();
    test_burst();
    test_early_release();
    test_backpressure();
    test_rr_wrap();
    test_reset_mid_burst();
    test_random_backpressure();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
